// File: rtl/wf_ring_fifo_at40.sv
// wf_ring_fifo_at40
// 40-entry circular FIFO of wavefront IDs. Pointers advance modulo 40 so
// they line up with the wavefront slot space. Issue/dispatch pushes IDs on
// the write end; the retire/free-slot tracker drains them in arrival order.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (pointers and count only)
//   flush      synchronous clear of pointers and count, beats push/pop
//   enq_valid  producer offers enq_data
//   enq_data   entry to write
//   enq_ready  not full (from registered count only)
//   deq_valid  not empty (from registered count only)
//   deq_data   oldest entry, read straight from storage
//   deq_ready  consumer takes deq_data
//   count      occupied entries, 0..40
module wf_ring_fifo_at40 #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned DEPTH      = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  enq_valid,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  enq_ready,
  output logic                  deq_valid,
  output logic [DATA_WIDTH-1:0] deq_data,
  input  logic                  deq_ready,
  output logic [5:0]            count
);

  localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);
  localparam logic [5:0] FULL_CNT = 6'(DEPTH);

  logic [DATA_WIDTH-1:0] storage [DEPTH];
  logic [5:0]            wr_ptr;
  logic [5:0]            rd_ptr;
  logic                  push;
  logic                  pop;

  // Pointers never hold 40: the slot after 39 is 0.
  function automatic logic [5:0] wrap_inc(input logic [5:0] p);
    return (p == LAST_IDX) ? '0 : p + 6'd1;
  endfunction

  // Handshake flags come from registered count only, so a pop in the same
  // cycle never opens enq_ready on a full FIFO.
  always_comb begin
    enq_ready = (count != FULL_CNT);
    deq_valid = (count != '0);
    push      = enq_valid & enq_ready;
    pop       = deq_valid & deq_ready;
  end

  always_comb begin
    deq_data = storage[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 6'd1;
        2'b01:   count <= count - 6'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; contents are only meaningful while
  // count says so.
  always_ff @(posedge clk) begin
    if (push && !flush) storage[wr_ptr] <= enq_data;
  end

endmodule
